// File: rtl/spi_slave_byte_if.sv
// Pin and byte-handshake bundle for spi_slave_byte; slave modport is the target's view.
interface spi_slave_byte_if;
  logic       i_spi_clk;
  logic       i_spi_cs_n;
  logic       i_spi_mosi;
  logic       o_spi_miso;
  logic       o_spi_miso_oe;
  logic [7:0] i_tx_byte;
  logic       i_tx_dv;
  logic       o_tx_ready;
  logic       o_rx_dv;
  logic [7:0] o_rx_byte;
  logic       o_tx_underrun;

  modport slave (
    input  i_spi_clk, i_spi_cs_n, i_spi_mosi, i_tx_byte, i_tx_dv,
    output o_spi_miso, o_spi_miso_oe, o_tx_ready, o_rx_dv, o_rx_byte, o_tx_underrun
  );

  modport master (
    output i_spi_clk, i_spi_cs_n, i_spi_mosi, i_tx_byte, i_tx_dv,
    input  o_spi_miso, o_spi_miso_oe, o_tx_ready, o_rx_dv, o_rx_byte, o_tx_underrun
  );
endinterface

// File: rtl/spi_slave_byte.sv
// SPI target: oversampled pins, MSB-first byte shifting, valid/ready TX holding register.
// Define SPI_SLAVE_UNDERRUN_EN to build the sticky TX underrun flag.
module spi_slave_byte #(
  parameter int unsigned SPI_MODE    = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             i_clk,
  input logic             i_reset_n,
  spi_slave_byte_if.slave bus
);
  localparam logic CPOL = 1'((SPI_MODE >> 1) & 32'd1);
  localparam logic CPHA = 1'(SPI_MODE & 32'd1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_q;
  logic       sclk_s, cs_low, mosi_s;
  logic       start, abort, active;
  logic       leading, trailing, sample_edge, shift_edge, byte_end;
  logic       load, bypass, tx_accept;
  logic [7:0] load_val;
  logic       hold_full;
  logic [7:0] hold;
  logic [7:0] tx_shift;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       skip_shift, load_due;
  logic       rx_dv;
  logic [7:0] rx_byte;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_low = !cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= CPOL;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_spi_mosi};
      sclk_q    <= sclk_s;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE:    if (cs_low)  begin state_d = ACTIVE; start = 1'b1; end
      ACTIVE:  if (!cs_low) begin state_d = IDLE;   abort = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  assign active      = (state_q == ACTIVE) && cs_low;
  assign leading     = active && (sclk_q == CPOL) && (sclk_s != CPOL);
  assign trailing    = active && (sclk_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trailing : leading;
  assign shift_edge  = CPHA ? leading  : trailing;
  assign byte_end    = sample_edge && (bit_cnt == 3'd7);

  // CPHA=1 reloads on the first leading edge of the following byte, so a
  // frame ending with CS rise does not consume the holding register.
  assign load      = start || (CPHA ? (shift_edge && load_due) : byte_end);
  assign tx_accept = bus.i_tx_dv && !hold_full;
  assign bypass    = load && tx_accept;

  always_comb begin
    load_val = '0;
    if (hold_full)        load_val = hold;
    else if (bus.i_tx_dv) load_val = bus.i_tx_byte;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_accept && !bypass) begin
      hold      <= bus.i_tx_byte;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      skip_shift <= 1'b0;
      load_due   <= 1'b0;
      rx_dv      <= 1'b0;
      rx_byte    <= '0;
    end else begin
      rx_dv <= 1'b0;
      if (abort) begin
        tx_shift   <= '0;
        bit_cnt    <= '0;
        skip_shift <= 1'b0;
        load_due   <= 1'b0;
      end else if (active) begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (byte_end) begin
            rx_byte <= {rx_shift, mosi_s};
            rx_dv   <= 1'b1;
            if (CPHA) load_due   <= 1'b1;
            else      skip_shift <= 1'b1;
          end
        end
        if (shift_edge) begin
          if (load_due)        load_due   <= 1'b0;
          else if (skip_shift) skip_shift <= 1'b0;
          else                 tx_shift   <= {tx_shift[6:0], 1'b0};
        end
      end
      if (start) begin
        bit_cnt    <= '0;
        skip_shift <= CPHA;
        load_due   <= 1'b0;
      end
      if (load) tx_shift <= load_val;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                           underrun_q <= 1'b0;
    else if (load && !hold_full && !bus.i_tx_dv) underrun_q <= 1'b1;
    else if (tx_accept)                       underrun_q <= 1'b0;
  end
  assign bus.o_tx_underrun = underrun_q;
`else
  assign bus.o_tx_underrun = 1'b0;
`endif

  // During the start cycle the MSB comes straight from the load source.
  assign bus.o_spi_miso    = cs_low && (start ? load_val[7] : tx_shift[7]);
  assign bus.o_spi_miso_oe = cs_low;
  assign bus.o_tx_ready    = !hold_full;
  assign bus.o_rx_dv       = rx_dv;
  assign bus.o_rx_byte     = rx_byte;
endmodule

// File: tb/tb_spi_slave_byte.sv
// Scoreboard bench: mode-3 and mode-0 targets driven by one SPI master, checked against a byte-level model.
module tb_spi_slave_byte;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_byte_if if3();
  spi_slave_byte_if if0();

  spi_slave_byte #(.SPI_MODE(3), .SYNC_STAGES(2)) u_m3 (.i_clk(clk), .i_reset_n(rst_n), .bus(if3.slave));
  spi_slave_byte #(.SPI_MODE(0), .SYNC_STAGES(2)) u_m0 (.i_clk(clk), .i_reset_n(rst_n), .bus(if0.slave));

  int tests = 0;
  int fails = 0;

  // Model state per target: index 0 = mode 3, index 1 = mode 0.
  logic       hold_full [2];
  logic [7:0] hold_val  [2];
  logic       urun      [2];
  logic [7:0] exp_rx3[$], exp_rx0[$];
  logic [7:0] em3[$], em0[$];

  logic [7:0] fb [4];
  logic       mw_en  [4][2];
  logic [7:0] mw_val [4][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic string tag(input int d);
    return (d == 0) ? "m3" : "m0";
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? if3.o_tx_ready : if0.o_tx_ready;
  endfunction

  function automatic logic get_urun(input int d);
    return (d == 0) ? if3.o_tx_underrun : if0.o_tx_underrun;
  endfunction

  function automatic logic get_oe(input int d);
    return (d == 0) ? if3.o_spi_miso_oe : if0.o_spi_miso_oe;
  endfunction

  function automatic logic exp_urun(input int d);
`ifdef SPI_SLAVE_UNDERRUN_EN
    return urun[d];
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_tx(input int d, input logic dv, input logic [7:0] b);
    if (d == 0) begin if3.i_tx_dv = dv; if3.i_tx_byte = b; end
    else        begin if0.i_tx_dv = dv; if0.i_tx_byte = b; end
  endtask

  task automatic set_cs(input logic v);
    if3.i_spi_cs_n = v;
    if0.i_spi_cs_n = v;
  endtask

  task automatic tx_write(input int d, input logic [7:0] b);
    check($sformatf("tx_ready_%s", tag(d)), get_ready(d), !hold_full[d]);
    set_tx(d, 1'b1, b);
    @(negedge clk);
    set_tx(d, 1'b0, 8'h00);
    if (!hold_full[d]) begin
      hold_full[d] = 1'b1;
      hold_val[d]  = b;
      urun[d]      = 1'b0;
    end
    @(negedge clk);
    check($sformatf("underrun_after_write_%s", tag(d)), get_urun(d), exp_urun(d));
  endtask

  // A byte slot begins: the target takes the held byte, or sends zeros.
  task automatic byte_start(input int d);
    logic [7:0] v;
    if (hold_full[d]) begin
      v = hold_val[d];
      hold_full[d] = 1'b0;
    end else begin
      v = 8'h00;
      urun[d] = 1'b1;
    end
    if (d == 0) em3.push_back(v);
    else        em0.push_back(v);
  endtask

  task automatic check_reset_vals();
    check("rst_miso_m3",  if3.o_spi_miso, 0);    check("rst_miso_m0",  if0.o_spi_miso, 0);
    check("rst_oe_m3",    if3.o_spi_miso_oe, 0); check("rst_oe_m0",    if0.o_spi_miso_oe, 0);
    check("rst_ready_m3", if3.o_tx_ready, 1);    check("rst_ready_m0", if0.o_tx_ready, 1);
    check("rst_rxdv_m3",  if3.o_rx_dv, 0);       check("rst_rxdv_m0",  if0.o_rx_dv, 0);
    check("rst_rxb_m3",   if3.o_rx_byte, 0);     check("rst_rxb_m0",   if0.o_rx_byte, 0);
    check("rst_urun_m3",  if3.o_tx_underrun, 0); check("rst_urun_m0",  if0.o_tx_underrun, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_cs(1'b1);
    if3.i_spi_clk = 1'b1;
    if0.i_spi_clk = 1'b0;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    wait_clk(2);
    check_reset_vals();
    for (int d = 0; d < 2; d++) begin
      hold_full[d] = 1'b0;
      urun[d]      = 1'b0;
    end
    exp_rx3.delete();
    exp_rx0.delete();
    rst_n = 1'b1;
    wait_clk(H);
  endtask

  task automatic clear_mw();
    for (int k = 0; k < 4; k++)
      for (int d = 0; d < 2; d++) begin
        mw_en[k][d]  = 1'b0;
        mw_val[k][d] = 8'h00;
      end
  endtask

  // Both targets sample on rising SCLK; mode 3 idles high, mode 0 idles low.
  task automatic run_frame(input int nb, input int last_bits, input logic rst_abort);
    logic [7:0] cap [2];
    int nbits;
    set_cs(1'b0);
    byte_start(0);
    byte_start(1);
    wait_clk(H);
    for (int k = 0; k < nb; k++) begin
      nbits  = (k == nb - 1) ? last_bits : 8;
      cap[0] = 8'h00;
      cap[1] = 8'h00;
      if (k > 0) byte_start(0);
      for (int i = 0; i < nbits; i++) begin
        if3.i_spi_clk  = 1'b0;
        if0.i_spi_clk  = 1'b0;
        if3.i_spi_mosi = fb[k][7-i];
        if0.i_spi_mosi = fb[k][7-i];
        wait_clk(H);
        if (i == 3)
          for (int d = 0; d < 2; d++)
            if (mw_en[k][d]) tx_write(d, mw_val[k][d]);
        cap[0] = {cap[0][6:0], if3.o_spi_miso};
        cap[1] = {cap[1][6:0], if0.o_spi_miso};
        if (i == 7) begin
          exp_rx3.push_back(fb[k]);
          exp_rx0.push_back(fb[k]);
          byte_start(1);
        end
        if3.i_spi_clk = 1'b1;
        if0.i_spi_clk = 1'b1;
        wait_clk(H);
      end
      if (nbits == 8) begin
        check("master_rx_m3", cap[0], em3.pop_front());
        check("master_rx_m0", cap[1], em0.pop_front());
      end
    end
    if0.i_spi_clk = 1'b0;
    wait_clk(H);
    if (rst_abort) apply_reset();
    else begin
      set_cs(1'b1);
      wait_clk(H);
    end
    em3.delete();
    em0.delete();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("idle_ready_%s", tag(d)), get_ready(d), !hold_full[d]);
      check($sformatf("idle_urun_%s", tag(d)), get_urun(d), exp_urun(d));
      check($sformatf("idle_oe_%s", tag(d)), get_oe(d), 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && if3.o_rx_dv === 1'b1) begin
      if (exp_rx3.size() == 0) check("rx_unexpected_m3", if3.o_rx_dv, 0);
      else                     check("rx_byte_m3", if3.o_rx_byte, exp_rx3.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && if0.o_rx_dv === 1'b1) begin
      if (exp_rx0.size() == 0) check("rx_unexpected_m0", if0.o_rx_dv, 0);
      else                     check("rx_byte_m0", if0.o_rx_byte, exp_rx0.pop_front());
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, last_bits;
    logic partial, rst_abort;
    set_cs(1'b1);
    if3.i_spi_clk = 1'b1;  if0.i_spi_clk = 1'b0;
    if3.i_spi_mosi = 1'b0; if0.i_spi_mosi = 1'b0;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      hold_full[d] = 1'b0;
      hold_val[d]  = 8'h00;
      urun[d]      = 1'b0;
    end
    wait_clk(1);
    apply_reset();

    // Preloaded byte returned while a byte is received.
    clear_mw();
    tx_write(0, 8'h5A); tx_write(1, 8'h5A);
    fb[0] = 8'hC1;
    run_frame(1, 8, 1'b0);

    // Two bytes with CS held low; second TX byte written mid-transfer.
    clear_mw();
    tx_write(0, 8'h11); tx_write(1, 8'h11);
    fb[0] = 8'hBE; fb[1] = 8'hEF;
    mw_en[0][0] = 1'b1; mw_val[0][0] = 8'h22;
    mw_en[0][1] = 1'b1; mw_val[0][1] = 8'h22;
    run_frame(2, 8, 1'b0);

    // Partial byte discarded, then a full byte with a fresh preload.
    clear_mw();
    fb[0] = 8'hFF;
    run_frame(1, 4, 1'b0);
    tx_write(0, 8'hA5); tx_write(1, 8'hA5);
    fb[0] = 8'h3C;
    run_frame(1, 8, 1'b0);

    // Underrun with nothing loaded; a write then clears the flag.
    clear_mw();
    fb[0] = 8'h77;
    run_frame(1, 8, 1'b0);
    tx_write(0, 8'h12); tx_write(1, 8'h34);
    tx_write(0, 8'h99);

    // Reset mid-byte, then a normal byte.
    fb[0] = 8'h5B;
    run_frame(1, 5, 1'b1);
    fb[0] = 8'h81;
    run_frame(1, 8, 1'b0);

    repeat (30) begin
      clear_mw();
      for (int d = 0; d < 2; d++)
        if ($urandom_range(3) != 0) tx_write(d, 8'($urandom));
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < nb; k++) begin
        fb[k] = 8'($urandom);
        for (int d = 0; d < 2; d++) begin
          mw_en[k][d]  = 1'($urandom_range(1));
          mw_val[k][d] = 8'($urandom);
        end
      end
      partial   = ($urandom_range(5) == 0);
      last_bits = partial ? int'($urandom_range(1, 7)) : 8;
      rst_abort = partial && ($urandom_range(1) == 1);
      run_frame(nb, last_bits, rst_abort);
    end

    wait_clk(H);
    check("rx_queue_drained_m3", exp_rx3.size(), 0);
    check("rx_queue_drained_m0", exp_rx0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
